// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared I2S definitions: word-length encoding,
// receiver states and default word geometry.
package I2sGlobalPkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_MAXIMUM_SIZE = 4;
  localparam int MAX_WORD_WIDTH =
    DEFAULT_DATA_WIDTH * DEFAULT_MAXIMUM_SIZE;

  typedef enum logic [1:0] {
    BITS_8,
    BITS_16,
    BITS_24,
    BITS_32
  } numOfBitsTransferEnum;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    SHIFT,
    HOLD
  } rxStateEnum;

  function automatic logic [5:0] bits_for_sel(
    input logic [1:0] sel
  );
    logic [5:0] n;
    n = 6'd8;
    unique case (numOfBitsTransferEnum'(sel))
      BITS_8:  n = 6'd8;
      BITS_16: n = 6'd16;
      BITS_24: n = 6'd24;
      BITS_32: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/i2s_input_sync.sv
// Two-flop synchronizers for the I2S lines and
// sclk rising-edge strobe in the clk domain.
module i2s_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic ws,
  input  logic sd,
  output logic rise_edge,
  output logic ws_sync,
  output logic sd_sync
);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic ws_s1, sd_s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ws_s1   <= 1'b0;
      ws_sync <= 1'b0;
      sd_s1   <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ws_s1   <= ws;
      ws_sync <= ws_s1;
      sd_s1   <= sd;
      sd_sync <= sd_s1;
    end
  end

  assign rise_edge = sclk_s2 & ~sclk_s3;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// Philips-format I2S slave receiver delivering
// right-aligned words on a valid/ready port.
module i2s_rx_deserializer
  import I2sGlobalPkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int MAXIMUM_SIZE = DEFAULT_MAXIMUM_SIZE,
  localparam int W = DATA_WIDTH * MAXIMUM_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sclk,
  input  logic         ws,
  input  logic         sd,
  input  logic [1:0]   numOfBitsSel,
  output logic [W-1:0] rxData,
  output logic         rxChannel,
  output logic         rxValid,
  input  logic         rxReady,
  output logic         overrun,
  output logic         frameError
);

  logic rise, ws_s, sd_s;

  i2s_input_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .ws        (ws),
    .sd        (sd),
    .rise_edge (rise),
    .ws_sync   (ws_s),
    .sd_sync   (sd_s)
  );

  rxStateEnum state, state_nxt;

  logic         ws_prev;
  logic         channel;
  logic [5:0]   bit_target;
  logic [5:0]   bit_count;
  logic [5:0]   cnt_inc;
  logic [W-1:0] shift_reg;
  logic [W-1:0] shift_nxt;
  logic         ws_change;

  logic do_latch, do_shift;
  logic word_done, frame_err;

  assign ws_change = rise && (ws_s != ws_prev);
  assign shift_nxt = {shift_reg[W-2:0], sd_s};
  assign cnt_inc   = (bit_count == 6'h3f) ?
                     bit_count : bit_count + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (ws_change) state_nxt = SYNC;
      SYNC, SHIFT:
        if (rise) begin
          if (ws_change)      state_nxt = SYNC;
          else if (word_done) state_nxt = HOLD;
          else                state_nxt = SHIFT;
        end
      HOLD:
        if (ws_change) state_nxt = SYNC;
    endcase
  end

  // The ws-change edge still carries the LSB of
  // the word in flight, so it may complete it.
  always_comb begin
    do_latch  = ws_change;
    do_shift  = 1'b0;
    word_done = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      SYNC, SHIFT:
        if (rise) begin
          do_shift = 1'b1;
          if (cnt_inc == bit_target)
            word_done = 1'b1;
          else if (ws_change)
            frame_err = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_prev    <= 1'b0;
      channel    <= 1'b0;
      bit_target <= 6'd0;
      bit_count  <= 6'd0;
      shift_reg  <= '0;
      rxData     <= '0;
      rxChannel  <= 1'b0;
      rxValid    <= 1'b0;
      overrun    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      overrun    <= 1'b0;
      frameError <= frame_err;
      if (rise) ws_prev <= ws_s;
      if (do_latch) begin
        bit_target <= bits_for_sel(numOfBitsSel);
        bit_count  <= 6'd0;
        shift_reg  <= '0;
        channel    <= ws_s;
      end else if (do_shift) begin
        bit_count  <= cnt_inc;
        shift_reg  <= shift_nxt;
      end
      if (word_done) begin
        rxData    <= shift_nxt;
        rxChannel <= channel;
        rxValid   <= 1'b1;
        overrun   <= rxValid && !rxReady;
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench: drives Philips I2S frames and
// checks recovered words and error pulses.
module tb_i2s_rx_deserializer;

  logic        clk = 1'b0;
  logic        reset, sclk, ws, sd, rxReady;
  logic [1:0]  numOfBitsSel;
  logic [31:0] rxData;
  logic        rxChannel, rxValid;
  logic        overrun, frameError;

  always #5 clk = ~clk;

  i2s_rx_deserializer dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .ws           (ws),
    .sd           (sd),
    .numOfBitsSel (numOfBitsSel),
    .rxData       (rxData),
    .rxChannel    (rxChannel),
    .rxValid      (rxValid),
    .rxReady      (rxReady),
    .overrun      (overrun),
    .frameError   (frameError)
  );

  typedef struct {
    logic        ch;
    logic [31:0] val;
    int          nbits;
    int          slot;
    logic [1:0]  sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  int pass_cnt = 0;
  int total    = 0;
  int ovr_cnt  = 0;
  int ferr_cnt = 0;
  logic [31:0] q_data[$];
  logic        q_ch[$];

  always @(negedge clk) begin
    if (rxValid && rxReady) begin
      q_data.push_back(rxData);
      q_ch.push_back(rxChannel);
    end
    if (overrun)    ovr_cnt++;
    if (frameError) ferr_cnt++;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] qd(input int i);
    if (q_data.size() > i) return q_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] qc(input int i);
    if (q_ch.size() > i) return {31'd0, q_ch[i]};
    return 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic w,
                          input logic d,
                          input logic acc);
    ws = w;
    sd = d;
    tick(4);
    sclk = 1'b1;
    tick(2);
    if (acc) rxReady = 1'b1;
    tick(1);
    if (acc) rxReady = 1'b0;
    tick(1);
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic ch,
                           input logic nxt,
                           input logic [31:0] val,
                           input int nbits,
                           input int slot,
                           input logic acc_last);
    for (int i = 0; i < slot; i++) begin
      logic w, d;
      w = (i == slot - 1) ? nxt : ch;
      d = 1'b1;
      if (i < nbits) d = val[nbits-1-i];
      send_bit(w, d, acc_last && (i == nbits - 1));
    end
  endtask

  task automatic clear_obs();
    q_data.delete();
    q_ch.delete();
    ovr_cnt  = 0;
    ferr_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic sync_up(input logic [1:0] sel,
                         input logic [31:0] val);
    numOfBitsSel = sel;
    for (int i = 0; i < 3; i++) send_bit(0, 0, 0);
    send_bit(1, 0, 0);
    send_word(1, 0, val, 8 * (sel + 1), 32, 0);
    tick(2);
    clear_obs();
  endtask

  task automatic run_group(input int lo,
                           input int hi);
    logic nxt;
    sync_up(vecs[lo].sel, 32'h0000_9999);
    for (int i = lo; i <= hi; i++) begin
      nxt = (i < hi) ? vecs[i+1].ch : ~vecs[i].ch;
      send_word(vecs[i].ch, nxt, vecs[i].val,
                vecs[i].nbits, vecs[i].slot, 0);
    end
    tick(4);
    chk("grp_count", q_data.size(), hi - lo + 1);
    for (int i = lo; i <= hi; i++) begin
      chk("grp_data", qd(i - lo), vecs[i].exp_data);
      chk("grp_ch", qc(i - lo), {31'd0, vecs[i].ch});
    end
    chk("grp_overrun", ovr_cnt, 0);
    chk("grp_frameerr", ferr_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 32'hA5C3, 16, 16, 2'd1, 32'h0000_A5C3};
    vecs[1] = '{1, 32'h1234, 16, 16, 2'd1, 32'h0000_1234};
    vecs[2] = '{0, 32'h81,    8, 32, 2'd0, 32'h0000_0081};
    vecs[3] = '{1, 32'h7E,    8, 32, 2'd0, 32'h0000_007E};

    reset = 1'b1;
    sclk = 1'b0;
    ws = 1'b0;
    sd = 1'b0;
    rxReady = 1'b1;
    numOfBitsSel = 2'd1;
    tick(3);
    chk("rst_data", rxData, 0);
    chk("rst_ch", {31'd0, rxChannel}, 0);
    chk("rst_valid", {31'd0, rxValid}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_frameerr", {31'd0, frameError}, 0);
    reset = 1'b0;
    tick(1);

    run_group(0, 1);
    do_reset();
    run_group(2, 3);

    do_reset();
    sync_up(2, 32'h00C0_FFEE);
    send_word(0, 1, 32'h0055_AA55, 24, 20, 0);
    tick(4);
    chk("ferr_pulse", ferr_cnt, 1);
    chk("ferr_noword", q_data.size(), 0);
    send_word(1, 0, 32'h00AB_CDEF, 24, 24, 0);
    tick(4);
    chk("ferr_after_cnt", q_data.size(), 1);
    chk("ferr_after_data", qd(0), 32'h00AB_CDEF);
    chk("ferr_after_ch", qc(0), 1);
    chk("ferr_once", ferr_cnt, 1);

    do_reset();
    sync_up(1, 32'h0000_0077);
    rxReady = 1'b0;
    send_word(0, 1, 32'h1111, 16, 16, 0);
    send_word(1, 0, 32'h2222, 16, 16, 0);
    tick(4);
    chk("ovr_pulse", ovr_cnt, 1);
    chk("ovr_valid", {31'd0, rxValid}, 1);
    chk("ovr_data", rxData, 32'h2222);
    chk("ovr_ch", {31'd0, rxChannel}, 1);
    chk("ovr_noacc", q_data.size(), 0);
    rxReady = 1'b1;
    tick(3);
    chk("ovr_acc_cnt", q_data.size(), 1);
    chk("ovr_acc_data", qd(0), 32'h2222);
    chk("ovr_valid_clr", {31'd0, rxValid}, 0);

    do_reset();
    sync_up(1, 32'h0000_0066);
    rxReady = 1'b0;
    send_word(0, 1, 32'h3333, 16, 16, 0);
    send_word(1, 0, 32'h4444, 16, 16, 1);
    tick(4);
    chk("sim_cnt", q_data.size(), 1);
    chk("sim_old", qd(0), 32'h3333);
    chk("sim_no_ovr", ovr_cnt, 0);
    chk("sim_valid", {31'd0, rxValid}, 1);
    chk("sim_new", rxData, 32'h4444);
    rxReady = 1'b1;
    tick(3);
    chk("sim_cnt2", q_data.size(), 2);
    chk("sim_new_acc", qd(1), 32'h4444);

    do_reset();
    rxReady = 1'b0;
    sync_up(3, 32'h5A5A_5A5A);
    chk("pre_rst_valid", {31'd0, rxValid}, 1);
    chk("pre_rst_data", rxData, 32'h5A5A_5A5A);
    for (int i = 0; i < 10; i++) send_bit(0, i[0], 0);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_data", rxData, 0);
    chk("mid_rst_valid", {31'd0, rxValid}, 0);
    chk("mid_rst_ch", {31'd0, rxChannel}, 0);
    reset = 1'b0;
    rxReady = 1'b1;
    clear_obs();
    for (int i = 0; i < 5; i++) send_bit(0, 1, 0);
    send_bit(1, 1, 0);
    send_word(1, 0, 32'hDEAD_BEEF, 32, 32, 0);
    tick(4);
    chk("post_rst_cnt", q_data.size(), 1);
    chk("post_rst_data", qd(0), 32'hDEAD_BEEF);
    chk("post_rst_ch", qc(0), 1);
    chk("post_rst_ferr", ferr_cnt, 0);
    chk("post_rst_ovr", ovr_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deserializer.md
# i2s_rx_deserializer

Synthesizable I2S receiver (slave) that recovers serial audio words from externally driven `sclk`/`ws`/`sd` and presents them as parallel words on a valid/ready interface. It is the receive-side counterpart to the I2S transmitter agents: it consumes the Philips-format stream they drive and serves as the RTL DUT for RX_SLAVE mode. All logic runs on the single system clock; I2S lines are treated as asynchronous inputs.

## Interface
- `DATA_WIDTH`, default 8: bits per byte lane.
- `MAXIMUM_SIZE`, default 4: byte lanes per word; max word = DATA_WIDTH*MAXIMUM_SIZE = 32.
- `clk`  input  1  system clock; must be ≥ 4× sclk frequency.
- `reset`  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `sclk`  input  1  I2S serial clock, asynchronous.
- `ws`  input  1  word select: 0 = left, 1 = right.
- `sd`  input  1  serial data, MSB first.
- `numOfBitsSel`  input  2  word length: 0→8, 1→16, 2→24, 3→32.
- `rxData`  output  32  received word, right-aligned, upper bits zero.
- `rxChannel`  output  1  channel of `rxData` (ws value of the word).
- `rxValid`  output  1  word available; held until accepted.
- `rxReady`  input  1  consumer accepts when `rxValid && rxReady`.
- `overrun`  output  1  one-clock pulse: a new word overwrote an unaccepted one.
- `frameError`  output  1  one-clock pulse: ws toggled before a full word was received.

## Operation
- 2-flop synchronizers on `sclk`, `ws`, `sd`; third `sclk` flop for edge detect. `riseEdge` = synced sclk 1 and delayed sclk 0. All sampling occurs only in `riseEdge` cycles, using the synced ws/sd from the same stage.
- `wsPrev` holds ws sampled at the previous `riseEdge`; `wsChange` = sampled ws ≠ `wsPrev`.
- Philips timing: the bit sampled in the `wsChange` edge is the LSB slot of the previous word; the MSB of the new word is sampled on the next `riseEdge`.
- States:
  - IDLE (reset): ignore data; on `wsChange` → SYNC. Partial first word discarded silently.
  - SYNC: latch `numOfBitsSel` into `bitTarget` (8/16/24/32), clear shift register and `bitCount`, latch channel = current ws; on next `riseEdge` shift in MSB, `bitCount`=1 → SHIFT (or complete immediately if target reached, impossible for ≥8).
  - SHIFT: each `riseEdge`, `shiftReg = {shiftReg[30:0], sd}`, `bitCount++`. If `wsChange` occurs before `bitCount == bitTarget` → pulse `frameError`, discard, → SYNC. When `bitCount` reaches `bitTarget` → word complete, → HOLD.
  - HOLD: ignore extra slot bits; on `wsChange` → SYNC.
- Word complete: load `rxData`/`rxChannel`, set `rxValid`. If `rxValid` was set and not accepted in that same cycle → `overrun` pulse, overwrite.
- Acceptance: `rxValid && rxReady` clears `rxValid` next cycle; simultaneous accept and new completion → new word loaded, `rxValid` stays 1, no overrun.
- `numOfBitsSel` change mid-word takes effect at the next SYNC only.
- `bitCount` 6 bits, saturating; never wraps.

## Timing
- Reset values: `rxData`=0, `rxChannel`=0, `rxValid`=0, `overrun`=0, `frameError`=0, state IDLE, synchronizers 0, `wsPrev`=0.
- Reset asserted mid-word: everything returns to reset values on the next clk; the in-flight word is lost with no error pulse.
- Input-to-`riseEdge` latency: 3 clk after the raw sclk rising edge is first sampled.
- `rxValid` asserts 1 clk after the `riseEdge` cycle that captured the final bit; `frameError` asserts 1 clk after the offending `riseEdge` cycle.
- sclk high and low phases must each be ≥ 2 clk; ws/sd must be stable across the sclk rising edge.

## Structure
- Shared package `I2sGlobalPkg` gains: `rxStateEnum` {IDLE, SYNC, SHIFT, HOLD}, constant `MAX_WORD_WIDTH = DATA_WIDTH*MAXIMUM_SIZE`, function mapping `numOfBitsSel` → bit count (aligned with `numOfBitsTransferEnum`).
- Sub-module `i2s_input_sync`: 2-flop synchronizers for sclk/ws/sd plus `riseEdge` generation; top holds the FSM, shift register, and output handshake.

## Test plan
- 16-bit stereo, clk:sclk = 8:1, left 0xA5C3, right 0x1234, `rxReady`=1 → two words in order: (0xA5C3, ch0), (0x1234, ch1); no error pulses.
- 8-bit words in 32-bit ws slots (ws period 64), data 0x81/0x7E → `rxData`=0x00000081/0x0000007E; padding bits ignored.
- 24-bit word; ws toggles after 20 bits → one `frameError` pulse, no `rxValid`; the following full word 0xABCDEF is received correctly.
- `rxReady`=0 across two completed words 0x1111, 0x2222 → `overrun` pulses once, `rxData`=0x2222, `rxValid` held 1.
- Accept in the same cycle as a new completion → new word presented, no overrun.
- Reset asserted mid-SHIFT, then a valid 32-bit word 0xDEADBEEF → outputs zero during reset; first partial word after reset discarded; 0xDEADBEEF is received after the next ws edge.
